// File: rtl/spdot_bsr_engine.sv
// spdot_bsr_engine: walks a BSR pattern and computes LANES-wide Q.K dot products per nonzero, folded into a checksum.
// Define SPDOT_SCORE_STREAM_EN to stream each score over valid/ready; otherwise the score port is tied off.
`default_nettype none

module spdot_bsr_engine #(
   parameter int DATA_W = 16,
   parameter int LANES  = 4,
   parameter int ADDR_W = 16,
   parameter int IDX_W  = 16,
   parameter int ACC_W  = 64
) (
   input  logic                    clk,
   input  logic                    rstn,
   input  logic                    start,
   input  logic [15:0]             m_rows,
   input  logic [15:0]             head_dim_d,
   input  logic [ADDR_W-1:0]       rowptr_base,
   input  logic [ADDR_W-1:0]       colidx_base,
   output logic [ADDR_W-1:0]       meta_raddr,
   input  logic [IDX_W-1:0]        meta_rdata,
   output logic [ADDR_W-1:0]       q_raddr,
   input  logic [LANES*DATA_W-1:0] q_rdata,
   output logic [ADDR_W-1:0]       k_raddr,
   input  logic [LANES*DATA_W-1:0] k_rdata,
   output logic                    score_valid,
   input  logic                    score_ready,
   output logic [ACC_W-1:0]        score_data,
   output logic [15:0]             score_row,
   output logic [IDX_W-1:0]        score_col,
   output logic                    busy,
   output logic                    done,
   output logic                    err,
   output logic [ACC_W-1:0]        checksum_out
);

   typedef enum logic [3:0] {
      S_IDLE     = 4'd0,
      S_PTR_A    = 4'd1,
      S_PTR_B    = 4'd2,
      S_PTR_C    = 4'd3,
      S_COL      = 4'd4,
      S_COL_W    = 4'd5,
      S_MAC      = 4'd6,
      S_DRAIN    = 4'd7,
      S_EMIT     = 4'd8,
      S_NEXT_ROW = 4'd9,
      S_FIN      = 4'd10,
      S_DONE     = 4'd11
   } state_t;

   state_t              state_q, state_d;
   logic [15:0]         i_q, i_d;
   logic [15:0]         rows_q, rows_d;
   logic [15:0]         hd_q, hd_d;
   logic [15:0]         dw_q, dw_d;
   logic [15:0]         w_q, w_d;
   logic [15:0]         w_pipe_q, w_pipe_d;
   logic [ADDR_W-1:0]   rp_base_q, rp_base_d;
   logic [ADDR_W-1:0]   ci_base_q, ci_base_d;
   logic [IDX_W-1:0]    lo_q, lo_d;
   logic [IDX_W-1:0]    hi_q, hi_d;
   logic [IDX_W-1:0]    p_q, p_d;
   logic [IDX_W-1:0]    col_q, col_d;
   logic                mac_vld_q, mac_vld_d;
   logic                emit_seen_q, emit_seen_d;
   logic                err_q, err_d;
   logic [ACC_W-1:0]    acc_q, acc_d;
   logic [ACC_W-1:0]    cks_q, cks_d;
   logic [ACC_W-1:0]    cks_out_q, cks_out_d;

   logic                       emit_fire;
   logic [ADDR_W-1:0]          qbase;
   logic [ADDR_W-1:0]          kbase;
   logic [ACC_W-1:0]           lane_sum;
   logic signed [2*DATA_W-1:0] prod;
   logic [31:0]                elem;

   // Products taken directly in ADDR_W so addresses wrap modulo 2^ADDR_W.
   assign qbase = ADDR_W'(i_q) * ADDR_W'(dw_q);
   assign kbase = ADDR_W'(col_q) * ADDR_W'(dw_q);

   // w_pipe_q tracks the word whose data arrives this cycle; lanes past head_dim_d are masked.
   always_comb begin
      lane_sum = '0;
      prod     = '0;
      elem     = '0;
      for (int l = 0; l < LANES; l++) begin
         prod = $signed(q_rdata[l*DATA_W +: DATA_W]) * $signed(k_rdata[l*DATA_W +: DATA_W]);
         elem = 32'(w_pipe_q) * 32'(LANES) + 32'(l);
         if (elem < 32'(hd_q)) begin
            lane_sum = lane_sum + ACC_W'(prod);
         end
      end
   end

`ifdef SPDOT_SCORE_STREAM_EN
   assign emit_fire   = score_ready;
   assign score_valid = (state_q == S_EMIT);
   assign score_data  = score_valid ? acc_q : '0;
   assign score_row   = score_valid ? i_q   : '0;
   assign score_col   = score_valid ? col_q : '0;
`else
   logic unused_score_ready;
   assign unused_score_ready = score_ready;
   assign emit_fire   = 1'b1;
   assign score_valid = 1'b0;
   assign score_data  = '0;
   assign score_row   = '0;
   assign score_col   = '0;
`endif

   always_comb begin
      state_d     = state_q;
      i_d         = i_q;
      rows_d      = rows_q;
      hd_d        = hd_q;
      dw_d        = dw_q;
      w_d         = w_q;
      rp_base_d   = rp_base_q;
      ci_base_d   = ci_base_q;
      lo_d        = lo_q;
      hi_d        = hi_q;
      p_d         = p_q;
      col_d       = col_q;
      err_d       = err_q;
      cks_d       = cks_q;
      cks_out_d   = cks_out_q;
      acc_d       = acc_q;
      mac_vld_d   = (state_q == S_MAC);
      w_pipe_d    = w_q;
      emit_seen_d = (state_q == S_EMIT);
      meta_raddr  = '0;
      q_raddr     = '0;
      k_raddr     = '0;

      if (mac_vld_q) begin
         acc_d = acc_q + lane_sum;
      end

      case (state_q)
         S_IDLE: begin
            if (start) begin
               cks_d     = '0;
               cks_out_d = '0;
               err_d     = 1'b0;
               i_d       = '0;
               rows_d    = m_rows;
               hd_d      = head_dim_d;
               dw_d      = 16'((17'(head_dim_d) + 17'(LANES - 1)) / 17'(LANES));
               rp_base_d = rowptr_base;
               ci_base_d = colidx_base;
               state_d   = (m_rows == 16'd0) ? S_FIN : S_PTR_A;
            end
         end
         S_PTR_A: begin
            meta_raddr = rp_base_q + ADDR_W'(i_q);
            state_d    = S_PTR_B;
         end
         S_PTR_B: begin
            meta_raddr = rp_base_q + ADDR_W'(i_q) + ADDR_W'(1);
            lo_d       = meta_rdata;
            state_d    = S_PTR_C;
         end
         S_PTR_C: begin
            hi_d = meta_rdata;
            if (meta_rdata < lo_q) begin
               err_d   = 1'b1;
               state_d = S_NEXT_ROW;
            end else if (meta_rdata == lo_q) begin
               state_d = S_NEXT_ROW;
            end else begin
               p_d     = lo_q;
               state_d = S_COL;
            end
         end
         S_COL: begin
            meta_raddr = ci_base_q + ADDR_W'(p_q);
            acc_d      = '0;
            state_d    = S_COL_W;
         end
         S_COL_W: begin
            col_d   = meta_rdata;
            w_d     = '0;
            state_d = (dw_q == 16'd0) ? S_EMIT : S_MAC;
         end
         S_MAC: begin
            q_raddr = qbase + ADDR_W'(w_q);
            k_raddr = kbase + ADDR_W'(w_q);
            if (w_q == dw_q - 16'd1) begin
               state_d = S_DRAIN;
            end else begin
               w_d = w_q + 16'd1;
            end
         end
         S_DRAIN: begin
            state_d = S_EMIT;
         end
         S_EMIT: begin
            // Fold once on entry so a stalled consumer cannot double-count.
            if (!emit_seen_q) begin
               cks_d = cks_q + acc_q;
            end
            if (emit_fire) begin
               p_d     = p_q + IDX_W'(1);
               state_d = ((p_q + IDX_W'(1)) < hi_q) ? S_COL : S_NEXT_ROW;
            end
         end
         S_NEXT_ROW: begin
            i_d     = i_q + 16'd1;
            state_d = ((17'(i_q) + 17'd1) < 17'(rows_q)) ? S_PTR_A : S_FIN;
         end
         S_FIN: begin
            cks_out_d = cks_q;
            state_d   = S_DONE;
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q     <= S_IDLE;
         i_q         <= '0;
         rows_q      <= '0;
         hd_q        <= '0;
         dw_q        <= '0;
         w_q         <= '0;
         w_pipe_q    <= '0;
         rp_base_q   <= '0;
         ci_base_q   <= '0;
         lo_q        <= '0;
         hi_q        <= '0;
         p_q         <= '0;
         col_q       <= '0;
         mac_vld_q   <= 1'b0;
         emit_seen_q <= 1'b0;
         err_q       <= 1'b0;
         acc_q       <= '0;
         cks_q       <= '0;
         cks_out_q   <= '0;
      end else begin
         state_q     <= state_d;
         i_q         <= i_d;
         rows_q      <= rows_d;
         hd_q        <= hd_d;
         dw_q        <= dw_d;
         w_q         <= w_d;
         w_pipe_q    <= w_pipe_d;
         rp_base_q   <= rp_base_d;
         ci_base_q   <= ci_base_d;
         lo_q        <= lo_d;
         hi_q        <= hi_d;
         p_q         <= p_d;
         col_q       <= col_d;
         mac_vld_q   <= mac_vld_d;
         emit_seen_q <= emit_seen_d;
         err_q       <= err_d;
         acc_q       <= acc_d;
         cks_q       <= cks_d;
         cks_out_q   <= cks_out_d;
      end
   end

   assign busy         = (state_q != S_IDLE) && (state_q != S_DONE);
   assign done         = (state_q == S_DONE);
   assign err          = err_q;
   assign checksum_out = cks_out_q;

endmodule

`default_nettype wire
